// File: rtl/rvfi_commit_packer_if.sv
// ROB-to-packer retire bus: two in-order commit slots plus the shared ready back-pressure.
interface rvfi_commit_packer_if #(
  parameter int WORD_W = 208
);
  logic              c0_valid;
  logic [WORD_W-1:0] c0_word;
  logic              c1_valid;
  logic [WORD_W-1:0] c1_word;
  logic              commit_ready;

  modport master (
    output c0_valid, c0_word, c1_valid, c1_word,
    input  commit_ready
  );

  modport slave (
    input  c0_valid, c0_word, c1_valid, c1_word,
    output commit_ready
  );
endinterface

// File: rtl/rvfi_commit_packer.sv
// Packs up to two ROB retirements per cycle into a serial RVFI packet stream,
// applying the late JALR target fix-up and x0 write-data masking on entry.
module rvfi_commit_packer #(
  parameter int DEPTH  = 8,
  parameter int WORD_W = 208
) (
  input  logic                 clk,
  input  logic                 rst,
  rvfi_commit_packer_if.slave  commit,
  input  logic                 jalr_resolve_valid,
  input  logic [31:0]          jalr_resolve_pc,
  output logic                 rvfi_valid,
  output logic [63:0]          rvfi_order,
  output logic [WORD_W-1:0]    rvfi_word,
  output logic                 overflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              fix_valid_r;
  logic [31:0]       fix_pc_r;
  logic [63:0]       emit_cnt_r;

  logic              ready_s;
  logic              push0_s;
  logic              push1_s;
  logic              pop_s;
  logic              err_s;
  logic              c0_fix_s;
  logic              c1_fix_s;
  logic [1:0]        push_cnt_s;
  logic [PTR_W-1:0]  wr_next_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [WORD_W-1:0] word0_s;
  logic [WORD_W-1:0] word1_s;

  function automatic logic is_jalr(input logic [WORD_W-1:0] w);
    return w[6:0] == 7'b1100111;
  endfunction

  function automatic logic [WORD_W-1:0] xform(input logic [WORD_W-1:0] w,
                                              input logic              use_fix,
                                              input logic [31:0]       fix_pc);
    logic [WORD_W-1:0] r;
    r = w;
    if (w[174:170] == 5'd0) r[206:175] = 32'd0;
    else                    r[206:175] = w[206:175];
    if (use_fix) r[95:64] = fix_pc;
    else         r[95:64] = w[95:64];
    return r;
  endfunction

  // Accept/drop decision, fix-up steering and FIFO bookkeeping for this cycle.
  always_comb begin
    ready_s = (count_r <= READY_MAX);
    push0_s = 1'b0;
    push1_s = 1'b0;
    if (commit.c0_valid && ready_s) begin
      push0_s = 1'b1;
      push1_s = commit.c1_valid;
    end else begin
      push0_s = 1'b0;
      push1_s = 1'b0;
    end
    err_s = ((commit.c0_valid || commit.c1_valid) && !ready_s) ||
            (commit.c1_valid && !commit.c0_valid);
    // An older JALR in slot 0 always claims the held target first.
    c0_fix_s    = push0_s && fix_valid_r && is_jalr(commit.c0_word);
    c1_fix_s    = push1_s && fix_valid_r && is_jalr(commit.c1_word) && !is_jalr(commit.c0_word);
    word0_s     = xform(commit.c0_word, c0_fix_s, fix_pc_r);
    word1_s     = xform(commit.c1_word, c1_fix_s, fix_pc_r);
    pop_s       = (count_r != {CNT_W{1'b0}});
    push_cnt_s  = {1'b0, push0_s} + {1'b0, push1_s};
    wr_next_s   = wr_ptr_r + PTR_ONE;
    count_nxt_s = count_r + CNT_W'(push_cnt_s) - CNT_W'(pop_s);
  end

  assign commit.commit_ready = ready_s;

  // FIFO storage, pointers, fix-up register and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      fix_valid_r  <= 1'b0;
      fix_pc_r     <= 32'd0;
      overflow_err <= 1'b0;
    end else begin
      if (push0_s) mem_r[wr_ptr_r]  <= word0_s;
      if (push1_s) mem_r[wr_next_s] <= word1_s;
      wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      // A same-cycle resolve is kept for the next JALR even when one consumes now.
      if (jalr_resolve_valid) begin
        fix_valid_r <= 1'b1;
        fix_pc_r    <= jalr_resolve_pc;
      end else if (c0_fix_s || c1_fix_s) begin
        fix_valid_r <= 1'b0;
      end
      if (err_s) overflow_err <= 1'b1;
    end
  end

  // Output stage: one registered packet per cycle with its sequence number.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvfi_valid <= 1'b0;
      rvfi_order <= 64'd0;
      rvfi_word  <= '0;
      emit_cnt_r <= 64'd0;
    end else if (pop_s) begin
      rvfi_valid <= 1'b1;
      rvfi_word  <= mem_r[rd_ptr_r];
      rvfi_order <= emit_cnt_r;
      emit_cnt_r <= emit_cnt_r + 64'd1;
    end else begin
      rvfi_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Directed self-checking bench for rvfi_commit_packer.
module tb_rvfi_commit_packer;
  localparam int WORD_W = 208;
  localparam logic [31:0] ADDI = 32'h00A00093;
  localparam logic [31:0] JALR = 32'h000080E7;
  localparam logic [31:0] NOP5 = 32'h00500293;

  logic              clk;
  logic              rst;
  logic              jalr_resolve_valid;
  logic [31:0]       jalr_resolve_pc;
  logic              rvfi_valid;
  logic [63:0]       rvfi_order;
  logic [WORD_W-1:0] rvfi_word;
  logic              overflow_err;

  int total;
  int bad;

  rvfi_commit_packer_if #(.WORD_W(WORD_W)) cbus ();

  rvfi_commit_packer #(.DEPTH(8), .WORD_W(WORD_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .commit             (cbus),
    .jalr_resolve_valid (jalr_resolve_valid),
    .jalr_resolve_pc    (jalr_resolve_pc),
    .rvfi_valid         (rvfi_valid),
    .rvfi_order         (rvfi_order),
    .rvfi_word          (rvfi_word),
    .overflow_err       (overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WORD_W-1:0] mk_word(input logic [31:0] inst, input logic [31:0] pc_r,
                                                input logic [31:0] pc_w, input logic [4:0] rd,
                                                input logic [31:0] rd_wd);
    logic [WORD_W-1:0] w;
    w = '0;
    w[31:0]    = inst;
    w[63:32]   = pc_r;
    w[95:64]   = pc_w;
    w[100:96]  = 5'd2;
    w[105:101] = 5'd3;
    w[137:106] = pc_r ^ 32'h1111_1111;
    w[169:138] = 32'h2222_2222;
    w[174:170] = rd;
    w[206:175] = rd_wd;
    w[207]     = 1'b1;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    cbus.c0_valid = 1'b0;
    cbus.c1_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_commit();
    jalr_resolve_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_dual(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1);
    cbus.c0_valid = 1'b1;
    cbus.c0_word  = w0;
    cbus.c1_valid = 1'b1;
    cbus.c1_word  = w1;
  endtask

  task automatic drive_single(input logic [WORD_W-1:0] w0);
    cbus.c0_valid = 1'b1;
    cbus.c0_word  = w0;
    cbus.c1_valid = 1'b0;
  endtask

  initial begin
    logic [WORD_W-1:0] w;
    int pushed;
    int got_n;
    int cyc;
    total = 0;
    bad   = 0;
    cbus.c0_valid = 1'b0;
    cbus.c1_valid = 1'b0;
    cbus.c0_word  = '0;
    cbus.c1_word  = '0;
    jalr_resolve_valid = 1'b0;
    jalr_resolve_pc    = 32'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 256'(rvfi_valid), 256'(1'b0));
    chk("rst_order", 256'(rvfi_order), 256'(64'd0));
    chk("rst_word", 256'(rvfi_word), 256'(0));
    chk("rst_ovf", 256'(overflow_err), 256'(1'b0));
    chk("rst_ready", 256'(cbus.commit_ready), 256'(1'b1));

    // single commit: one cycle after the FIFO write
    w = mk_word(ADDI, 32'h0, 32'h4, 5'd1, 32'd10);
    drive_single(w);
    tick();
    clear_commit();
    chk("t1_nobypass", 256'(rvfi_valid), 256'(1'b0));
    tick();
    chk("t1_valid", 256'(rvfi_valid), 256'(1'b1));
    chk("t1_order", 256'(rvfi_order), 256'(64'd0));
    chk("t1_word", 256'(rvfi_word), 256'(w));
    tick();
    chk("t1_idle", 256'(rvfi_valid), 256'(1'b0));

    // dual commit ordering
    do_reset();
    drive_dual(mk_word(ADDI, 32'h60, 32'h64, 5'd1, 32'd1), mk_word(ADDI, 32'h64, 32'h68, 5'd2, 32'd2));
    tick();
    clear_commit();
    tick();
    chk("t2_v0", 256'(rvfi_valid), 256'(1'b1));
    chk("t2_o0", 256'(rvfi_order), 256'(64'd0));
    chk("t2_w0", 256'(rvfi_word), 256'(mk_word(ADDI, 32'h60, 32'h64, 5'd1, 32'd1)));
    tick();
    chk("t2_v1", 256'(rvfi_valid), 256'(1'b1));
    chk("t2_o1", 256'(rvfi_order), 256'(64'd1));
    chk("t2_w1", 256'(rvfi_word), 256'(mk_word(ADDI, 32'h64, 32'h68, 5'd2, 32'd2)));
    tick();
    chk("t2_idle", 256'(rvfi_valid), 256'(1'b0));

    // x0 write data is masked
    drive_single(mk_word(ADDI, 32'h70, 32'h74, 5'd0, 32'h1234));
    tick();
    clear_commit();
    tick();
    chk("t3_order", 256'(rvfi_order), 256'(64'd2));
    chk("t3_word", 256'(rvfi_word), 256'(mk_word(ADDI, 32'h70, 32'h74, 5'd0, 32'h0)));

    // JALR fix-up
    do_reset();
    jalr_resolve_valid = 1'b1;
    jalr_resolve_pc    = 32'h8000_0100;
    tick();
    jalr_resolve_valid = 1'b0;
    tick();
    tick();
    drive_single(mk_word(JALR, 32'h100, 32'h0, 5'd1, 32'h104));
    tick();
    clear_commit();
    tick();
    chk("t4_order", 256'(rvfi_order), 256'(64'd0));
    chk("t4_fix", 256'(rvfi_word), 256'(mk_word(JALR, 32'h100, 32'h8000_0100, 5'd1, 32'h104)));
    drive_single(mk_word(JALR, 32'h200, 32'h208, 5'd1, 32'h204));
    tick();
    clear_commit();
    tick();
    chk("t4_nofix", 256'(rvfi_word), 256'(mk_word(JALR, 32'h200, 32'h208, 5'd1, 32'h204)));
    jalr_resolve_valid = 1'b1;
    jalr_resolve_pc    = 32'h300;
    tick();
    // dual JALR with a fresh resolve in the same cycle
    jalr_resolve_pc = 32'h400;
    drive_dual(mk_word(JALR, 32'h300, 32'h0, 5'd1, 32'h1), mk_word(JALR, 32'h304, 32'h30C, 5'd1, 32'h2));
    tick();
    clear_commit();
    jalr_resolve_valid = 1'b0;
    tick();
    chk("t4_dual0", 256'(rvfi_word), 256'(mk_word(JALR, 32'h300, 32'h300, 5'd1, 32'h1)));
    tick();
    chk("t4_dual1_ord", 256'(rvfi_order), 256'(64'd3));
    chk("t4_dual1", 256'(rvfi_word), 256'(mk_word(JALR, 32'h304, 32'h30C, 5'd1, 32'h2)));
    drive_single(mk_word(JALR, 32'h400, 32'h0, 5'd1, 32'h3));
    tick();
    clear_commit();
    tick();
    chk("t4_held", 256'(rvfi_word), 256'(mk_word(JALR, 32'h400, 32'h400, 5'd1, 32'h3)));

    // sustained dual retire fills the FIFO
    do_reset();
    pushed = 0;
    got_n  = 0;
    cyc    = 0;
    while (got_n < 20 && cyc < 200) begin
      if (rvfi_valid) begin
        chk("fill_order", 256'(rvfi_order), 256'(got_n));
        chk("fill_word", 256'(rvfi_word),
            256'(mk_word(NOP5, 32'(4 * got_n), 32'(4 * got_n + 4), 5'd5, 32'(got_n))));
        got_n++;
      end
      if (cyc == 6) chk("fill_full", 256'(cbus.commit_ready), 256'(1'b0));
      if (cyc == 7) chk("fill_reopen", 256'(cbus.commit_ready), 256'(1'b1));
      if (pushed < 20 && cbus.commit_ready) begin
        drive_dual(mk_word(NOP5, 32'(4 * pushed), 32'(4 * pushed + 4), 5'd5, 32'(pushed)),
                   mk_word(NOP5, 32'(4 * pushed + 4), 32'(4 * pushed + 8), 5'd5, 32'(pushed + 1)));
        pushed += 2;
      end else begin
        clear_commit();
      end
      tick();
      cyc++;
    end
    clear_commit();
    chk("fill_count", 256'(got_n), 256'(20));
    chk("fill_ovf", 256'(overflow_err), 256'(1'b0));

    // forced commit while full, then mid-stream reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_dual(mk_word(NOP5, 32'(8 * i), 32'h0, 5'd5, 32'd0), mk_word(NOP5, 32'(8 * i + 4), 32'h0, 5'd5, 32'd0));
      tick();
    end
    chk("ovf_ready", 256'(cbus.commit_ready), 256'(1'b0));
    tick();
    clear_commit();
    chk("ovf_set", 256'(overflow_err), 256'(1'b1));
    tick();
    chk("ovf_sticky", 256'(overflow_err), 256'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", 256'(rvfi_valid), 256'(1'b0));
    chk("mid_order", 256'(rvfi_order), 256'(64'd0));
    chk("mid_ovf", 256'(overflow_err), 256'(1'b0));
    chk("mid_ready", 256'(cbus.commit_ready), 256'(1'b1));
    tick();
    chk("mid_flushed", 256'(rvfi_valid), 256'(1'b0));

    // slot 1 without slot 0 is illegal and ignored
    do_reset();
    cbus.c1_valid = 1'b1;
    cbus.c1_word  = mk_word(ADDI, 32'h900, 32'h904, 5'd1, 32'd9);
    tick();
    clear_commit();
    chk("c1only_ovf", 256'(overflow_err), 256'(1'b1));
    tick();
    chk("c1only_drop0", 256'(rvfi_valid), 256'(1'b0));
    tick();
    chk("c1only_drop1", 256'(rvfi_valid), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
